// File: rtl/frog_controller.sv
// frog_controller: four raw direction buttons -> synchronised, debounced press
// events -> one queued move, applied only on frame_tick so the frog never
// tears mid-frame. Also handles respawn on death or on reaching the top row,
// and keeps a saturating crossing score.
// Optional build macro FROG_WRAP_EN: horizontal moves wrap around the screen
// instead of clamping at the walls.
module frog_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int GRID_SIZE       = 32,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int START_X         = 320,
  parameter int START_Y         = 448
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       frame_tick,
  input  logic       frog_die,
  output logic [9:0] frog_x,
  output logic [9:0] frog_y,
  output logic       frog_win,
  output logic [7:0] score
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // 11-bit signed intermediates so a step below 0 is a negative number, not a wrap
  localparam logic signed [10:0] STEP  = 11'(GRID_SIZE);
  localparam logic signed [10:0] MAX_X = 11'(SCREEN_W - GRID_SIZE);
  localparam logic signed [10:0] MAX_Y = 11'(SCREEN_H - GRID_SIZE);
  localparam logic [9:0]         RESPAWN_X = 10'(START_X);
  localparam logic [9:0]         RESPAWN_Y = 10'(START_Y);

  typedef enum logic [2:0] {
    MV_NONE  = 3'd0,
    MV_UP    = 3'd1,
    MV_DOWN  = 3'd2,
    MV_LEFT  = 3'd3,
    MV_RIGHT = 3'd4
  } move_e;

  // Keep a position inside [0, hi]
  function automatic logic signed [10:0] clamp_pos(input logic signed [10:0] v,
                                                   input logic signed [10:0] hi);
    if (v < 11'sd0)   clamp_pos = 11'sd0;
    else if (v > hi)  clamp_pos = hi;
    else              clamp_pos = v;
  endfunction

  // Horizontal limit handling: wrap to the opposite wall, or clamp
  function automatic logic signed [10:0] horiz_pos(input logic signed [10:0] v);
`ifdef FROG_WRAP_EN
    if (v < 11'sd0)     horiz_pos = MAX_X;
    else if (v > MAX_X) horiz_pos = 11'sd0;
    else                horiz_pos = v;
`else
    horiz_pos = clamp_pos(v, MAX_X);
`endif
  endfunction

  // Crossing counter that holds at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Button vector order: [3]=up [2]=down [1]=left [0]=right
  logic [3:0] btn_raw;
  assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       press;
  move_e            press_mv;
  move_e            pend_q, pend_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             win_q, win_d;
  logic [7:0]       score_q, score_d;
  logic signed [10:0] x_s, y_s, nx_s, ny_s;

  // Two-flop synchroniser for the asynchronous buttons
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  // Per-button debounce: count while synced differs from debounced, accept on the last count
  always_comb begin
    deb_d = deb_q;
    press = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
          press[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Same-cycle presses resolve with priority up > down > left > right
  always_comb begin
    press_mv = MV_NONE;
    if (press[3])      press_mv = MV_UP;
    else if (press[2]) press_mv = MV_DOWN;
    else if (press[1]) press_mv = MV_LEFT;
    else if (press[0]) press_mv = MV_RIGHT;
  end

  // Candidate position after applying the pending move, with wall handling
  always_comb begin
    x_s  = signed'({1'b0, x_q});
    y_s  = signed'({1'b0, y_q});
    nx_s = x_s;
    ny_s = y_s;
    case (pend_q)
      MV_UP:    ny_s = clamp_pos(y_s - STEP, MAX_Y);
      MV_DOWN:  ny_s = clamp_pos(y_s + STEP, MAX_Y);
      MV_LEFT:  nx_s = horiz_pos(x_s - STEP);
      MV_RIGHT: nx_s = horiz_pos(x_s + STEP);
      default:  ;
    endcase
  end

  // Frame-tick update: die > top-row win > pending move > hold; pending queue control
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    win_d   = 1'b0;
    score_d = score_q;
    pend_d  = pend_q;
    if (frame_tick) begin
      // A press landing on the tick itself is kept for the next frame
      pend_d = press_mv;
      if (frog_die) begin
        x_d = RESPAWN_X;
        y_d = RESPAWN_Y;
      end else if (y_q == 10'd0) begin
        x_d     = RESPAWN_X;
        y_d     = RESPAWN_Y;
        win_d   = 1'b1;
        score_d = sat_inc8(score_q);
      end else begin
        x_d = 10'(nx_s);
        y_d = 10'(ny_s);
      end
    end else if (pend_q == MV_NONE) begin
      pend_d = press_mv;
    end
  end

  // State registers; reset discards debounce progress and any queued move
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
      deb_q   <= 4'b0000;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      pend_q  <= MV_NONE;
      x_q     <= RESPAWN_X;
      y_q     <= RESPAWN_Y;
      win_q   <= 1'b0;
      score_q <= 8'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      pend_q  <= pend_d;
      x_q     <= x_d;
      y_q     <= y_d;
      win_q   <= win_d;
      score_q <= score_d;
    end
  end

  assign frog_x   = x_q;
  assign frog_y   = y_q;
  assign frog_win = win_q;
  assign score    = score_q;

endmodule

// File: tb/tb_frog_controller.sv
// Directed testbench for frog_controller with a short debounce window.
module tb_frog_controller;

  localparam logic [3:0] B_UP    = 4'b1000;
  localparam logic [3:0] B_DOWN  = 4'b0100;
  localparam logic [3:0] B_LEFT  = 4'b0010;
  localparam logic [3:0] B_RIGHT = 4'b0001;

  logic       clk;
  logic       rst_n;
  logic [3:0] btns;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       frame_tick;
  logic       frog_die;
  logic [9:0] frog_x;
  logic [9:0] frog_y;
  logic       frog_win;
  logic [7:0] score;

  int checks = 0;
  int fails  = 0;

  assign {btn_up, btn_down, btn_left, btn_right} = btns;

  frog_controller #(
    .DEBOUNCE_CYCLES(4),
    .GRID_SIZE(32),
    .SCREEN_W(640),
    .SCREEN_H(480),
    .START_X(320),
    .START_Y(448)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .frame_tick(frame_tick),
    .frog_die(frog_die),
    .frog_x(frog_x),
    .frog_y(frog_y),
    .frog_win(frog_win),
    .score(score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    btns = 4'b0000;
    frame_tick = 1'b0;
    frog_die = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic press(input logic [3:0] mask);
    btns = mask;
    repeat (6) @(negedge clk);
    btns = 4'b0000;
    repeat (6) @(negedge clk);
  endtask

  task automatic crossing();
    for (int i = 0; i < 14; i++) begin
      press(B_UP);
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (frog_x !== 10'd320) begin fails++; $display("FAIL reset_x: got %0d want 320", frog_x); end
    checks++; if (frog_y !== 10'd448) begin fails++; $display("FAIL reset_y: got %0d want 448", frog_y); end
    checks++; if (score !== 8'd0) begin fails++; $display("FAIL reset_score: got %0d want 0", score); end
    checks++; if (frog_win !== 1'b0) begin fails++; $display("FAIL reset_win: got %0b want 0", frog_win); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (frog_x !== 10'd320 || frog_y !== 10'd448) begin fails++; $display("FAIL idle_tick%0d: got %0d/%0d want 320/448", i, frog_x, frog_y); end
    end
  endtask

  task automatic test_debounce();
    do_reset();
    btns = B_UP;
    repeat (2) @(negedge clk);
    btns = 4'b0000;
    repeat (8) @(negedge clk);
    tick();
    checks++; if (frog_y !== 10'd448) begin fails++; $display("FAIL glitch: frog_y=%0d want 448", frog_y); end
    btns = B_UP;
    repeat (10) @(negedge clk);
    tick();
    checks++; if (frog_y !== 10'd416) begin fails++; $display("FAIL held_up: frog_y=%0d want 416", frog_y); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (frog_y !== 10'd416) begin fails++; $display("FAIL no_repeat%0d: frog_y=%0d want 416", i, frog_y); end
    end
    btns = 4'b0000;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_clamp();
    do_reset();
    press(B_DOWN);
    tick();
    checks++; if (frog_y !== 10'd448) begin fails++; $display("FAIL down_clamp: frog_y=%0d want 448", frog_y); end
    press(B_LEFT);
    tick();
    checks++; if (frog_x !== 10'd288) begin fails++; $display("FAIL left_1: frog_x=%0d want 288", frog_x); end
    for (int i = 0; i < 9; i++) begin
      press(B_LEFT);
      tick();
    end
    checks++; if (frog_x !== 10'd0) begin fails++; $display("FAIL left_10: frog_x=%0d want 0", frog_x); end
    press(B_LEFT);
    tick();
`ifdef FROG_WRAP_EN
    checks++; if (frog_x !== 10'd608) begin fails++; $display("FAIL left_wall: frog_x=%0d want 608", frog_x); end
    press(B_RIGHT);
    tick();
    checks++; if (frog_x !== 10'd0) begin fails++; $display("FAIL right_wall: frog_x=%0d want 0", frog_x); end
`else
    checks++; if (frog_x !== 10'd0) begin fails++; $display("FAIL left_wall: frog_x=%0d want 0", frog_x); end
    press(B_RIGHT);
    tick();
    checks++; if (frog_x !== 10'd32) begin fails++; $display("FAIL right_step: frog_x=%0d want 32", frog_x); end
`endif
  endtask

  task automatic test_priority();
    do_reset();
    btns = B_UP | B_RIGHT;
    repeat (6) @(negedge clk);
    btns = 4'b0000;
    repeat (6) @(negedge clk);
    press(B_RIGHT);
    tick();
    checks++; if (frog_y !== 10'd416 || frog_x !== 10'd320) begin fails++; $display("FAIL prio: got %0d/%0d want 320/416", frog_x, frog_y); end
    tick();
    checks++; if (frog_y !== 10'd416 || frog_x !== 10'd320) begin fails++; $display("FAIL dropped_right: got %0d/%0d want 320/416", frog_x, frog_y); end
  endtask

  task automatic test_tick_press_same_cycle();
    do_reset();
    btns = B_UP;
    repeat (5) @(negedge clk);
    tick();
    checks++; if (frog_y !== 10'd448) begin fails++; $display("FAIL press_on_tick_now: frog_y=%0d want 448", frog_y); end
    btns = 4'b0000;
    repeat (6) @(negedge clk);
    tick();
    checks++; if (frog_y !== 10'd416) begin fails++; $display("FAIL press_on_tick_next: frog_y=%0d want 416", frog_y); end
  endtask

  task automatic test_crossing();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      press(B_UP);
      tick();
    end
    checks++; if (frog_y !== 10'd0 || frog_x !== 10'd320) begin fails++; $display("FAIL top_row: got %0d/%0d want 320/0", frog_x, frog_y); end
    checks++; if (frog_win !== 1'b0) begin fails++; $display("FAIL win_early: got %0b want 0", frog_win); end
    tick();
    checks++; if (frog_win !== 1'b1) begin fails++; $display("FAIL win_pulse: got %0b want 1", frog_win); end
    checks++; if (frog_x !== 10'd320 || frog_y !== 10'd448) begin fails++; $display("FAIL win_respawn: got %0d/%0d want 320/448", frog_x, frog_y); end
    checks++; if (score !== 8'd1) begin fails++; $display("FAIL score_1: got %0d want 1", score); end
    @(negedge clk);
    checks++; if (frog_win !== 1'b0) begin fails++; $display("FAIL win_width: got %0b want 0", frog_win); end
    for (int c = 0; c < 254; c++) crossing();
    checks++; if (score !== 8'd255) begin fails++; $display("FAIL score_255: got %0d want 255", score); end
    for (int i = 0; i < 14; i++) begin
      press(B_UP);
      tick();
    end
    tick();
    checks++; if (frog_win !== 1'b1 || score !== 8'd255) begin fails++; $display("FAIL score_sat: win=%0b score=%0d want 1/255", frog_win, score); end
  endtask

  task automatic test_die_and_reset();
    do_reset();
    press(B_LEFT);
    tick();
    checks++; if (frog_x !== 10'd288) begin fails++; $display("FAIL pre_die: frog_x=%0d want 288", frog_x); end
    press(B_UP);
    frog_die = 1'b1;
    tick();
    frog_die = 1'b0;
    checks++; if (frog_x !== 10'd320 || frog_y !== 10'd448) begin fails++; $display("FAIL die_respawn: got %0d/%0d want 320/448", frog_x, frog_y); end
    checks++; if (score !== 8'd0 || frog_win !== 1'b0) begin fails++; $display("FAIL die_score: score=%0d win=%0b want 0/0", score, frog_win); end
    tick();
    checks++; if (frog_y !== 10'd448) begin fails++; $display("FAIL die_pending: frog_y=%0d want 448", frog_y); end
    // Reset partway through debouncing an up press
    btns = B_UP;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    btns = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    tick();
    checks++; if (frog_y !== 10'd448) begin fails++; $display("FAIL reset_mid_debounce: frog_y=%0d want 448", frog_y); end
    // Reset with a move already queued; reset must act without a clock edge
    press(B_LEFT);
    tick();
    press(B_UP);
    rst_n = 1'b0;
    #1;
    checks++; if (frog_x !== 10'd320) begin fails++; $display("FAIL async_reset: frog_x=%0d want 320", frog_x); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tick();
    checks++; if (frog_y !== 10'd448 || frog_x !== 10'd320) begin fails++; $display("FAIL reset_pending: got %0d/%0d want 320/448", frog_x, frog_y); end
  endtask

  initial begin
    rst_n = 1'b0;
    btns = 4'b0000;
    frame_tick = 1'b0;
    frog_die = 1'b0;
    @(negedge clk);
    test_reset();
    test_debounce();
    test_clamp();
    test_priority();
    test_tick_press_same_cycle();
    test_crossing();
    test_die_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
